// File: rtl/uart_rx_ctrl_pkg.sv
// uart_rx_ctrl_pkg: frame states, minimum oversampling ratio and bit-counter width helper for the UART RX controller
package uart_rx_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam int MIN_PRESCALE = 4;
  function automatic int bit_cnt_w(input int data_width);
    return $clog2(data_width + 3);
  endfunction
endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// uart_rx_edge_bit_counter: oversample edge and frame bit counters (CLK, RST async low, load=start at edge 1, clr, Prescale -> edge_count, bit_count, last_edge)
module uart_rx_edge_bit_counter import uart_rx_ctrl_pkg::*; #(
  parameter int Data_Width = 8
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              load,
  input  logic                              clr,
  input  logic [5:0]                        Prescale,
  output logic [5:0]                        edge_count,
  output logic [bit_cnt_w(Data_Width)-1:0] bit_count,
  output logic                              last_edge
);
  localparam int BW = bit_cnt_w(Data_Width);
  assign last_edge = {1'b0, edge_count} + 7'd1 >= {1'b0, Prescale};
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      edge_count <= '0;
      bit_count <= '0;
    end else if (load) begin
      edge_count <= 6'd1;
      bit_count <= '0;
    end else if (clr) begin
      edge_count <= '0;
      bit_count <= '0;
    end else begin
      edge_count <= last_edge ? 6'd0 : edge_count + 6'd1;
      bit_count <= last_edge ? bit_count + BW'(1) : bit_count;
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART RX frame sequencer (CLK, RST async low, RX_IN, Prescale, PAR_EN, checker results in; counters, sub-block enables, result pulses, busy out)
module uart_rx_ctrl import uart_rx_ctrl_pkg::*; #(
  parameter int Data_Width = 8
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              RX_IN,
  input  logic [5:0]                        Prescale,
  input  logic                              PAR_EN,
  input  logic                              strt_glitch,
  input  logic                              par_err,
  input  logic                              stp_err,
  output logic [5:0]                        edge_count,
  output logic [bit_cnt_w(Data_Width)-1:0] bit_count,
  output logic                              dat_samp_en,
  output logic                              deser_en,
  output logic                              strt_chk_en,
  output logic                              par_chk_en,
  output logic                              stp_chk_en,
  output logic                              data_valid,
  output logic                              par_err_o,
  output logic                              frm_err_o,
  output logic                              busy
);
  localparam int BW = bit_cnt_w(Data_Width);
  state_t state, nxt;
  logic rx_q, par_en_q, par_flag, last_edge, start, stop_done;
  assign start = !rx_q && Prescale >= 6'(MIN_PRESCALE);
  assign stop_done = state == STOP && last_edge;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? START : IDLE;
      START:   nxt = !last_edge ? START : strt_glitch ? IDLE : DATA;
      DATA:    nxt = !(last_edge && bit_count == BW'(Data_Width)) ? DATA : par_en_q ? PARITY : STOP;
      PARITY:  nxt = last_edge ? STOP : PARITY;
      STOP:    nxt = last_edge ? IDLE : STOP;
      default: nxt = IDLE;
    endcase
  end
  uart_rx_edge_bit_counter #(.Data_Width(Data_Width)) u_cnt (
    .CLK(CLK),
    .RST(RST),
    .load(state == IDLE && nxt == START),
    .clr(nxt == IDLE),
    .Prescale(Prescale),
    .edge_count(edge_count),
    .bit_count(bit_count),
    .last_edge(last_edge)
  );
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state <= IDLE;
      rx_q <= 1'b1;
      par_en_q <= 1'b0;
      par_flag <= 1'b0;
      busy <= 1'b0;
      dat_samp_en <= 1'b0;
      strt_chk_en <= 1'b0;
      deser_en <= 1'b0;
      par_chk_en <= 1'b0;
      stp_chk_en <= 1'b0;
      data_valid <= 1'b0;
      par_err_o <= 1'b0;
      frm_err_o <= 1'b0;
    end else begin
      state <= nxt;
      rx_q <= RX_IN;
      par_en_q <= state == IDLE ? PAR_EN : par_en_q;
      par_flag <= state == IDLE ? 1'b0 : state == PARITY && last_edge ? par_err : par_flag;
      busy <= nxt != IDLE;
      dat_samp_en <= nxt != IDLE;
      strt_chk_en <= nxt == START;
      deser_en <= nxt == DATA;
      par_chk_en <= nxt == PARITY;
      stp_chk_en <= nxt == STOP;
      data_valid <= stop_done && !par_flag && !stp_err;
      par_err_o <= stop_done && par_flag;
      frm_err_o <= stop_done && !par_flag && stp_err;
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench for uart_rx_ctrl against a cycle-index frame model
module tb_uart_rx_ctrl;
  localparam int DW = 8;
  localparam int BW = $clog2(DW + 3);
  typedef struct {int kind; int cyc;} exp_t;
  logic CLK = 0, RST = 0, RX_IN = 1, PAR_EN = 0, strt_glitch = 0, par_err = 0, stp_err = 0;
  logic [5:0] Prescale = 6'd8;
  logic [5:0] edge_count;
  logic [BW-1:0] bit_count;
  logic dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, par_err_o, frm_err_o, busy;
  exp_t q[$];
  exp_t m_e;
  int n_vec, n_err, cyc;
  bit e_busy, e_strt, e_deser, e_par, e_stp;
  int e_edge, e_bit;
  uart_rx_ctrl #(.Data_Width(DW)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
    .edge_count(edge_count), .bit_count(bit_count), .dat_samp_en(dat_samp_en),
    .deser_en(deser_en), .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en),
    .stp_chk_en(stp_chk_en), .data_valid(data_valid), .par_err_o(par_err_o),
    .frm_err_o(frm_err_o), .busy(busy)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge CLK) if (RST) begin
    chk("busy", busy, e_busy);
    chk("dat_samp_en", dat_samp_en, e_busy);
    chk("strt_chk_en", strt_chk_en, e_strt);
    chk("deser_en", deser_en, e_deser);
    chk("par_chk_en", par_chk_en, e_par);
    chk("stp_chk_en", stp_chk_en, e_stp);
    chk("edge_count", edge_count, e_edge);
    chk("bit_count", bit_count, e_bit);
    if (data_valid || par_err_o || frm_err_o) begin
      if (q.size() == 0) chk("spurious_pulse", {frm_err_o, par_err_o, data_valid}, 0);
      else begin
        m_e = q.pop_front();
        chk("pulse_kind", {frm_err_o, par_err_o, data_valid}, m_e.kind);
        chk("pulse_cycle", cyc, m_e.cyc);
      end
    end else if (q.size() != 0 && cyc >= q[0].cyc) begin
      chk("pulse_missing", 0, q[0].kind);
      void'(q.pop_front());
    end
  end
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic idle_exp();
    {e_busy, e_strt, e_deser, e_par, e_stp} = '0;
    e_edge = 0;
    e_bit = 0;
  endtask
  task automatic rnd_chk();
    strt_glitch = 1'($urandom);
    par_err = 1'($urandom);
    stp_err = 1'($urandom);
  endtask
  task automatic chk_zero(input string name);
    chk(name, int'({busy, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
                    data_valid, par_err_o, frm_err_o, edge_count, bit_count}), 0);
  endtask
  function automatic logic line_at(int j, int p, int len, bit g, bit all_low, bit pe, logic [DW-1:0] d);
    int b = j / p;
    if (j >= len) return 1'b1;
    if (g) return 1'(j >= 2);
    if (all_low || b == 0) return 1'b0;
    if (b <= DW) return d[b-1];
    if (pe && b == DW + 1) return ^d;
    return 1'b1;
  endfunction
  task automatic frame(input int p, input bit pe, input logic [DW-1:0] d, input bit g, input bit pb,
                       input bit sb, input bit all_low, input int rst_at, input int gap);
    int n, len, e0;
    bit aborted;
    exp_t x;
    n = g ? 1 : DW + 2 + int'(pe);
    len = p * n;
    aborted = 0;
    Prescale = 6'(p);
    PAR_EN = pe;
    RX_IN = 1'b0;
    idle_exp();
    rnd_chk();
    tick();
    e0 = cyc;
    if (!g) begin
      x.kind = pe && pb ? 2 : sb ? 4 : 1;
      x.cyc = e0 + len;
      q.push_back(x);
    end
    for (int c = 0; c < len; c++) begin
      int b = c / p;
      bit in_f = c >= 1;
      RX_IN = line_at(c + 1, p, len, g, all_low, pe, d);
      if (in_f) PAR_EN = 1'($urandom);
      strt_glitch = in_f && b == 0 ? g : 1'($urandom);
      par_err = in_f && pe && b == DW + 1 ? pb : 1'($urandom);
      stp_err = in_f && !g && b == n - 1 ? sb : 1'($urandom);
      e_busy = in_f;
      e_strt = in_f && b == 0;
      e_deser = in_f && b >= 1 && b <= DW;
      e_par = in_f && !g && pe && b == DW + 1;
      e_stp = in_f && !g && b == n - 1;
      e_edge = in_f ? c % p : 0;
      e_bit = in_f ? b : 0;
      if (c == rst_at) begin
        RST = 1'b0;
        RX_IN = 1'b1;
        idle_exp();
        #1;
        chk_zero("midframe_reset_outputs");
        tick();
        RST = 1'b1;
        if (!g) void'(q.pop_back());
        aborted = 1;
        break;
      end
      tick();
    end
    RX_IN = 1'b1;
    idle_exp();
    rnd_chk();
    repeat (gap + int'(aborted)) tick();
  endtask
  task automatic idle_low(input int p, input int k);
    Prescale = 6'(p);
    idle_exp();
    repeat (k) begin
      RX_IN = 1'b0;
      rnd_chk();
      tick();
    end
    RX_IN = 1'b1;
    repeat (3) tick();
  endtask
  initial begin
    idle_exp();
    rnd_chk();
    repeat (3) @(posedge CLK);
    #1;
    chk_zero("reset_outputs");
    RST = 1'b1;
    repeat (2) tick();
    frame(8, 0, 8'hA5, 0, 0, 0, 0, -1, 3);
    frame(16, 1, 8'h3C, 0, 1, 0, 0, -1, 2);
    frame(8, 0, 8'h00, 1, 0, 0, 0, -1, 4);
    frame(8, 0, 8'h5A, 0, 0, 1, 0, -1, 0);
    frame(8, 0, 8'hC3, 0, 0, 0, 0, -1, 2);
    frame(8, 1, 8'h81, 0, 0, 0, 0, 4 * 8 + 3, 2);
    frame(32, 0, 8'h96, 0, 0, 0, 0, -1, 1);
    idle_low(2, 3);
    idle_low(3, 2);
    frame(4, 1, 8'h7E, 0, 0, 0, 0, -1, 0);
    frame(8, 1, 8'h11, 0, 1, 1, 0, -1, 1);
    frame(8, 0, 8'h00, 0, 0, 1, 1, -1, 0);
    frame(5, 1, 8'hF0, 0, 0, 1, 0, -1, 0);
    for (int i = 0; i < 25; i++) begin
      int p = $urandom_range(32, 4);
      bit pe = 1'($urandom);
      bit g = $urandom_range(5, 0) == 0;
      int len = p * (g ? 1 : DW + 2 + int'(pe));
      int ra = $urandom_range(7, 0) == 0 ? $urandom_range(len - 1, 0) : -1;
      frame(p, pe, 8'($urandom), g, 1'($urandom), 1'($urandom), $urandom_range(7, 0) == 0, ra, $urandom_range(3, 0));
    end
    repeat (3) tick();
    chk("pulses_outstanding", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
